// File: rtl/lc3_mmio_bridge.sv
// LC-3 memory-port bridge: forwards RAM accesses and decodes the keyboard, display and MCR device page.
// Optional FE08 cycle counter is enabled by defining LC3_MMIO_CYCLE_COUNTER_EN.
`timescale 1ns/1ps
module lc3_mmio_bridge #(
    parameter int          KB_FIFO_DEPTH = 4,
    parameter logic [15:0] MMIO_BASE     = 16'hFE00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        writeEnable,
    input  logic [15:0] address,
    input  logic [15:0] dataToMemory,
    output logic [15:0] dataFromMemory,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        kb_valid,
    input  logic [7:0]  kb_data,
    output logic        kb_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data,
    input  logic        dsp_ready,
    output logic        halted
);

    localparam int          PTR_W         = (KB_FIFO_DEPTH > 1) ? $clog2(KB_FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] KB_FULL_COUNT = (PTR_W + 1)'(KB_FIFO_DEPTH);

    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] MCR_ADDR  = 16'hFFFE;
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
    localparam logic [15:0] CNT_ADDR  = 16'hFE08;
`endif

    localparam logic [0:0] DSP_IDLE = 1'b0;
    localparam logic [0:0] DSP_BUSY = 1'b1;

    logic             in_dev;
    logic [15:0]      last_addr;
    logic [15:0]      dev_rdata;

    logic [7:0]       kb_mem [KB_FIFO_DEPTH];
    logic [PTR_W-1:0] kb_rd_ptr;
    logic [PTR_W-1:0] kb_wr_ptr;
    logic [PTR_W:0]   kb_count;
    logic             kb_empty;
    logic             kb_full;
    logic             kb_push;
    logic             kb_pop;
    logic             kbdr_access;

    logic [0:0]       dsp_state;
    logic             dsp_overrun;
    logic             ddr_wr;

    logic             mcr_en;
    logic             mcr_wr;

    // Main memory path: pass-through with zero added latency.
    assign in_dev    = (address >= MMIO_BASE);
    assign mem_addr  = address;
    assign mem_wdata = dataToMemory;
    assign mem_we    = writeEnable && !in_dev;

    assign kb_empty    = (kb_count == '0);
    assign kb_full     = (kb_count == KB_FULL_COUNT);
    assign kb_ready    = !kb_full;
    // A held KBDR address is one access; only the first cycle of it pops.
    assign kbdr_access = (address == KBDR_ADDR) && (last_addr != KBDR_ADDR);
    assign kb_push     = kb_valid && !kb_full;
    assign kb_pop      = kbdr_access && !kb_empty;

    assign ddr_wr    = writeEnable && (address == DDR_ADDR);
    assign mcr_wr    = writeEnable && (address == MCR_ADDR);
    assign dsp_valid = (dsp_state == DSP_BUSY);
    assign halted    = !mcr_en;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_addr <= '0;
        end else begin
            last_addr <= address;
        end
    end

    always_ff @(posedge clk) begin
        if (kb_push) begin
            kb_mem[kb_wr_ptr] <= kb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kb_rd_ptr <= '0;
            kb_wr_ptr <= '0;
            kb_count  <= '0;
        end else begin
            if (kb_push) begin
                kb_wr_ptr <= kb_wr_ptr + 1'b1;
            end
            if (kb_pop) begin
                kb_rd_ptr <= kb_rd_ptr + 1'b1;
            end
            case ({kb_push, kb_pop})
                2'b10:   kb_count <= kb_count + 1'b1;
                2'b01:   kb_count <= kb_count - 1'b1;
                default: kb_count <= kb_count;
            endcase
        end
    end

    // Display holding register; a store while a character is pending is lost and flagged.
    always_ff @(posedge clk) begin
        if (reset) begin
            dsp_state   <= DSP_IDLE;
            dsp_data    <= '0;
            dsp_overrun <= 1'b0;
        end else begin
            case (dsp_state)
                DSP_IDLE: begin
                    if (ddr_wr) begin
                        dsp_state <= DSP_BUSY;
                        dsp_data  <= dataToMemory[7:0];
                    end
                end
                DSP_BUSY: begin
                    if (ddr_wr) begin
                        dsp_overrun <= 1'b1;
                    end
                    if (dsp_ready) begin
                        dsp_state <= DSP_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcr_en <= 1'b1;
        end else if (mcr_wr) begin
            mcr_en <= dataToMemory[15];
        end
    end

`ifdef LC3_MMIO_CYCLE_COUNTER_EN
    logic [15:0] cycle_cnt;
    logic        cnt_wr;

    assign cnt_wr = writeEnable && (address == CNT_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (cnt_wr) begin
            cycle_cnt <= '0;
        end else if (mcr_en) begin
            cycle_cnt <= cycle_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        dev_rdata = 16'h0000;
        case (address)
            KBSR_ADDR: dev_rdata = {!kb_empty, 15'b0};
            KBDR_ADDR: dev_rdata = {8'h00, kb_empty ? 8'h00 : kb_mem[kb_rd_ptr]};
            DSR_ADDR:  dev_rdata = {!dsp_valid, dsp_overrun, 14'b0};
            MCR_ADDR:  dev_rdata = {mcr_en, 15'b0};
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
            CNT_ADDR:  dev_rdata = cycle_cnt;
`endif
            default:   dev_rdata = 16'h0000;
        endcase
    end

    assign dataFromMemory = in_dev ? dev_rdata : mem_rdata;

endmodule

// File: tb/tb_lc3_mmio_bridge.sv
// Bench for lc3_mmio_bridge: directed scenarios then random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_lc3_mmio_bridge;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [15:0] address;
    logic [15:0] dataToMemory;
    logic [15:0] dataFromMemory;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        dsp_valid;
    logic [7:0]  dsp_data;
    logic        dsp_ready;
    logic        halted;

    always #5 clk = ~clk;

    // Environment RAM, written only by the DUT's memory port.
    logic [15:0] mem [256];
    assign mem_rdata = mem[mem_addr[7:0]];

    lc3_mmio_bridge #(.KB_FIFO_DEPTH(DEPTH), .MMIO_BASE(16'hFE00)) dut (
        .clk(clk), .reset(reset), .writeEnable(writeEnable), .address(address),
        .dataToMemory(dataToMemory), .dataFromMemory(dataFromMemory),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .kb_valid(kb_valid), .kb_data(kb_data), .kb_ready(kb_ready),
        .dsp_valid(dsp_valid), .dsp_data(dsp_data), .dsp_ready(dsp_ready), .halted(halted)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  kbq [$];
    logic [15:0] m_last;
    bit          m_busy;
    logic [7:0]  m_dsp;
    bit          m_ovr;
    bit          m_mcr;
    logic [15:0] ref_mem [256];
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
    logic [15:0] m_cnt;
`endif

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        if (a < 16'hFE00) return ref_mem[a[7:0]];
        case (a)
            16'hFE00: return kbq.size() > 0 ? 16'h8000 : 16'h0000;
            16'hFE02: return kbq.size() > 0 ? {8'h00, kbq[0]} : 16'h0000;
            16'hFE04: return {!m_busy, m_ovr, 14'b0};
            16'hFFFE: return {m_mcr, 15'b0};
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
            16'hFE08: return m_cnt;
`endif
            default:  return 16'h0000;
        endcase
    endfunction

    task automatic step(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input logic kv, input logic [7:0] kd, input logic dr, input bit rst = 1'b0);
        bit          cw;
        logic [15:0] ca, cd;
        int          sz;
        bit          push, pop, ddr;
        reset = rst; writeEnable = we; address = a; dataToMemory = d;
        kb_valid = kv; kb_data = kd; dsp_ready = dr;
        #1;
        if (!rst) begin
            chk("rdata",     dataFromMemory,  exp_read(a));
            chk("mem_we",    16'(mem_we),     16'(we && (a < 16'hFE00)));
            chk("mem_addr",  mem_addr,        a);
            chk("mem_wdata", mem_wdata,       d);
            chk("kb_ready",  16'(kb_ready),   16'(kbq.size() < DEPTH));
            chk("dsp_valid", 16'(dsp_valid),  16'(m_busy));
            chk("dsp_data",  16'(dsp_data),   16'(m_dsp));
            chk("halted",    16'(halted),     16'(!m_mcr));
        end
        cw = mem_we; ca = mem_addr; cd = mem_wdata;
        @(posedge clk);
        if (cw) mem[ca[7:0]] = cd;
        if (rst) begin
            kbq.delete(); m_last = 16'h0; m_busy = 0; m_dsp = 8'h0; m_ovr = 0; m_mcr = 1;
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
            m_cnt = 16'h0;
`endif
        end else begin
            sz   = kbq.size();
            push = kv && (sz < DEPTH);
            pop  = (a == 16'hFE02) && (m_last != 16'hFE02) && (sz > 0);
            ddr  = we && (a == 16'hFE06);
            if (pop) kbq.delete(0);
            if (push) kbq.push_back(kd);
            if (m_busy) begin
                if (ddr) m_ovr = 1;
                if (dr) m_busy = 0;
            end else if (ddr) begin
                m_busy = 1; m_dsp = d[7:0];
            end
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
            if (we && a == 16'hFE08) m_cnt = 16'h0;
            else if (m_mcr) m_cnt = m_cnt + 16'd1;
`endif
            if (we && a == 16'hFFFE) m_mcr = d[15];
            if (we && a < 16'hFE00) ref_mem[a[7:0]] = d;
            m_last = a;
        end
        #1;
    endtask

    task automatic peek(input logic [15:0] a, input string tag, input logic [15:0] expv);
        writeEnable = 1'b0; address = a;
        #1;
        chk(tag, dataFromMemory, expv);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 16'h0000, 16'h0, 0, 8'h0, 0);
    endtask

    initial begin
        logic [15:0] ra, rd;
        bit          rw;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 16'h0; ref_mem[i] = 16'h0;
        end
        kbq.delete(); m_last = 16'h0; m_busy = 0; m_dsp = 8'h0; m_ovr = 0; m_mcr = 1;
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
        m_cnt = 16'h0;
`endif
        step(0, 16'h0, 16'h0, 0, 8'h0, 0, 1'b1);
        step(0, 16'h0, 16'h0, 0, 8'h0, 0, 1'b1);
        idle(1);
        chk("rst_kb_ready", 16'(kb_ready), 16'h1);
        chk("rst_halted", 16'(halted), 16'h0);
        chk("rst_dsp_valid", 16'(dsp_valid), 16'h0);
        chk("rst_dsp_data", 16'(dsp_data), 16'h0);

        // Store then load through to RAM
        step(1, 16'h3000, 16'h1234, 0, 8'h0, 0);
        step(0, 16'h3000, 16'h0, 0, 8'h0, 0);
        peek(16'h3000, "load_3000", 16'h1234);

        // Keyboard: two characters, then pop both
        step(0, 16'h0, 16'h0, 1, 8'h41, 0);
        step(0, 16'h0, 16'h0, 1, 8'h42, 0);
        kb_valid = 0;
        peek(16'hFE00, "kbsr_full", 16'h8000);
        peek(16'hFE02, "kbdr_A", 16'h0041);
        step(0, 16'hFE02, 16'h0, 0, 8'h0, 0);
        step(0, 16'hFE02, 16'h0, 0, 8'h0, 0);
        peek(16'hFE02, "kbdr_held_B", 16'h0042);
        idle(1);
        peek(16'hFE02, "kbdr_B", 16'h0042);
        step(0, 16'hFE02, 16'h0, 0, 8'h0, 0);
        idle(1);
        peek(16'hFE00, "kbsr_empty", 16'h0000);
        peek(16'hFE02, "kbdr_empty", 16'h0000);

        // Overfill the FIFO
        for (int i = 0; i < 5; i++) step(0, 16'h0, 16'h0, 1, 8'h61 + 8'(i), 0);
        chk("kb_ready_full", 16'(kb_ready), 16'h0);
        step(0, 16'hFE02, 16'h0, 1, 8'h65, 0);
        chk("kb_ready_after_pop", 16'(kb_ready), 16'h1);
        step(0, 16'h0, 16'h0, 1, 8'h65, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 16'hFE02, 16'h0, 0, 8'h0, 0);
            idle(1);
        end
        peek(16'hFE00, "kbsr_drained", 16'h0000);

        // Display holding register and overrun
        step(1, 16'hFE06, 16'h0048, 0, 8'h0, 0);
        chk("dsp_valid_set", 16'(dsp_valid), 16'h1);
        chk("dsp_data_48", 16'(dsp_data), 16'h0048);
        peek(16'hFE04, "dsr_busy", 16'h0000);
        peek(16'hFE06, "ddr_reads0", 16'h0000);
        step(1, 16'hFE06, 16'h0055, 0, 8'h0, 0);
        peek(16'hFE04, "dsr_overrun", 16'h4000);
        chk("dsp_data_kept", 16'(dsp_data), 16'h0048);
        step(0, 16'h0, 16'h0, 0, 8'h0, 1);
        peek(16'hFE04, "dsr_idle_ovr", 16'hC000);

        // MCR
        step(1, 16'hFFFE, 16'h0000, 0, 8'h0, 0);
        chk("halted_set", 16'(halted), 16'h1);
        peek(16'hFFFE, "mcr_read0", 16'h0000);
        step(1, 16'hFFFE, 16'hFFFF, 0, 8'h0, 0);
        chk("halted_clr", 16'(halted), 16'h0);
        peek(16'hFFFE, "mcr_read1", 16'h8000);

        // Cycle counter (or unmapped FE08)
        step(1, 16'hFE08, 16'h1234, 0, 8'h0, 0);
        idle(10);
`ifdef LC3_MMIO_CYCLE_COUNTER_EN
        peek(16'hFE08, "cnt_10", 16'h000A);
`else
        peek(16'hFE08, "fe08_unmapped", 16'h0000);
`endif
        peek(16'hFE0A, "unmapped", 16'h0000);

        // Reset mid-operation
        step(0, 16'h0, 16'h0, 1, 8'h70, 0);
        step(1, 16'hFE06, 16'h0033, 0, 8'h0, 0);
        step(1, 16'hFFFE, 16'h0000, 0, 8'h0, 0);
        step(0, 16'h0, 16'h0, 0, 8'h0, 0, 1'b1);
        idle(1);
        chk("rst2_dsp_valid", 16'(dsp_valid), 16'h0);
        chk("rst2_halted", 16'(halted), 16'h0);
        chk("rst2_kb_ready", 16'(kb_ready), 16'h1);
        peek(16'hFE00, "rst2_kbsr", 16'h0000);
        peek(16'hFE04, "rst2_dsr", 16'h8000);

        // Random traffic
        ra = 16'h3000;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 9))
                    0, 1, 2: ra = 16'h3000 | 16'($urandom_range(0, 255));
                    3:       ra = 16'hFE00;
                    4:       ra = 16'hFE02;
                    5:       ra = 16'hFE04;
                    6:       ra = 16'hFE06;
                    7:       ra = 16'hFE08;
                    8:       ra = 16'hFFFE;
                    default: ra = 16'hFE0A + 16'($urandom_range(0, 100) * 2);
                endcase
            end
            rw = ($urandom_range(0, 3) == 0);
            rd = 16'($urandom);
            if (ra == 16'hFFFE) rd[15] = ($urandom_range(0, 3) != 0);
            step(rw, ra, rd, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
